// File: rtl/nn_pkg.sv
// nn_pkg: shared classifier constants, FSM state and class-index type
package nn_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int DATA_W = 16;
  localparam int IDX_W = 4;
  localparam logic [15:0] Q15_ONE = 16'h8000;
  localparam logic [15:0] Q15_HALF = 16'h4000;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  typedef logic [IDX_W-1:0] cls_t;
endpackage

// File: rtl/argmax_classifier_top2_tracker.sv
// top2_tracker: running best/second-best value and index over a serial scan
// ports: clk, rst (async, high); init marks element 0, en steps one element (v at index i);
//        best_val/best_idx and sec_val/sec_idx hold the running top-2
module top2_tracker #(
  parameter int DATA_W = 16,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              en,
  input  logic [DATA_W-1:0] v,
  input  logic [IDX_W-1:0]  i,
  output logic [DATA_W-1:0] best_val,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DATA_W-1:0] sec_val,
  output logic [IDX_W-1:0]  sec_idx
);
  // strict compares keep the lower index on every tie
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      best_val <= '0;
      best_idx <= '0;
      sec_val <= '0;
      sec_idx <= '0;
    end else if (en && init) begin
      best_val <= v;
      best_idx <= i;
      sec_val <= '0;
      sec_idx <= IDX_W'(1);
    end else if (en && v > best_val) begin
      sec_val <= best_val;
      sec_idx <= best_idx;
      best_val <= v;
      best_idx <= i;
    end else if (en && v > sec_val) begin
      sec_val <= v;
      sec_idx <= i;
    end
endmodule

// File: rtl/argmax_classifier.sv
// argmax_classifier: serial top-1/top-2 search over a captured probability vector
// ports: clk, rst (async, high); prob_in/in_valid/in_ready frame input;
//        class_out/conf_out/second_out/margin_out/low_conf result with out_valid/out_ready;
//        frame_count (accepted results) and drop_count (refused frames), both saturating
module argmax_classifier #(
  parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int IDX_W = nn_pkg::IDX_W,
  parameter logic [DATA_W-1:0] CONF_THRESH = DATA_W'(nn_pkg::Q15_HALF),
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLASSES*DATA_W-1:0] prob_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [IDX_W-1:0]              class_out,
  output logic [DATA_W-1:0]             conf_out,
  output logic [IDX_W-1:0]              second_out,
  output logic [DATA_W-1:0]             margin_out,
  output logic                          low_conf,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              frame_count,
  output logic [CNT_W-1:0]              drop_count
);
  import nn_pkg::*;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);
  state_t state;
  logic [IDX_W-1:0] idx;
  logic fin;
  logic [DATA_W-1:0] cap [NUM_CLASSES];
  logic [DATA_W-1:0] best_val, sec_val;
  logic [IDX_W-1:0] best_idx, sec_idx;
  logic take, done;
  assign in_ready = !rst && (state == IDLE || (state == HOLD && out_ready));
  assign take = in_valid && in_ready;
  assign done = out_valid && out_ready;
  top2_tracker #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_top2 (
    .clk(clk),
    .rst(rst),
    .init(idx == '0),
    .en(state == SCAN && !fin),
    .v(cap[idx]),
    .i(idx),
    .best_val(best_val),
    .best_idx(best_idx),
    .sec_val(sec_val),
    .sec_idx(sec_idx)
  );
  // fin marks the extra cycle after the last element, where the tracker's
  // final values are copied into the output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      fin <= 1'b0;
      cap <= '{default: '0};
      class_out <= '0;
      conf_out <= '0;
      second_out <= '0;
      margin_out <= '0;
      low_conf <= 1'b0;
      out_valid <= 1'b0;
      frame_count <= '0;
      drop_count <= '0;
    end else begin
      if (take)
        for (int k = 0; k < NUM_CLASSES; k++) cap[k] <= prob_in[k*DATA_W +: DATA_W];
      if (in_valid && !in_ready && ~&drop_count) drop_count <= drop_count + 1'b1;
      if (done && ~&frame_count) frame_count <= frame_count + 1'b1;
      if (done) out_valid <= 1'b0;
      if (take) begin
        state <= SCAN;
        idx <= '0;
        fin <= 1'b0;
      end else if (state == SCAN && !fin) begin
        fin <= idx == LAST;
        idx <= idx == LAST ? idx : idx + 1'b1;
      end else if (state == SCAN) begin
        state <= HOLD;
        fin <= 1'b0;
        out_valid <= 1'b1;
        class_out <= best_idx;
        conf_out <= best_val;
        second_out <= sec_idx;
        margin_out <= best_val - sec_val;
        low_conf <= best_val < CONF_THRESH;
      end else if (done) begin
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed vector table plus handshake, drop and reset sequences
module tb_argmax_classifier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [159:0] prob_in = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] class_out, second_out;
  logic [15:0] conf_out, margin_out;
  logic low_conf, out_valid;
  logic out_ready = 1'b1;
  logic [15:0] frame_count, drop_count;
  int n_vec = 0;
  int n_err = 0;

  argmax_classifier dut (
    .clk(clk), .rst(rst), .prob_in(prob_in), .in_valid(in_valid), .in_ready(in_ready),
    .class_out(class_out), .conf_out(conf_out), .second_out(second_out),
    .margin_out(margin_out), .low_conf(low_conf), .out_valid(out_valid),
    .out_ready(out_ready), .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [159:0] prob;
    logic [3:0]   cls;
    logic [15:0]  conf;
    logic [3:0]   sec;
    logic [15:0]  margin;
    logic         low;
  } vec_t;

  function automatic logic [159:0] pk(input int c0, c1, c2, c3, c4, c5, c6, c7, c8, c9);
    return {16'(c9), 16'(c8), 16'(c7), 16'(c6), 16'(c5), 16'(c4), 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [159:0] p);
    @(negedge clk);
    prob_in = p;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t e);
    check({tag, ".class"}, 32'(class_out), 32'(e.cls));
    check({tag, ".conf"}, 32'(conf_out), 32'(e.conf));
    check({tag, ".second"}, 32'(second_out), 32'(e.sec));
    check({tag, ".margin"}, 32'(margin_out), 32'(e.margin));
    check({tag, ".low"}, 32'(low_conf), 32'(e.low));
  endtask

  initial begin
    vec_t tbl [6];
    vec_t held;
    int cyc, bad;
    tbl[0] = '{pk(100, 200, 9000, 300, 20000, 50, 0, 7, 1000, 400), 4'd4, 16'd20000, 4'd2, 16'd11000, 1'b0};
    tbl[1] = '{pk(4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096), 4'd0, 16'h1000, 4'd1, 16'd0, 1'b1};
    tbl[2] = '{pk(1000, 1000, 1000, 30000, 1000, 1000, 1000, 30000, 1000, 1000), 4'd3, 16'd30000, 4'd7, 16'd0, 1'b0};
    tbl[3] = '{pk('h7000, 'hF000, 'h7000, 'h7000, 'h7000, 'h7000, 'h7000, 'h7000, 'h7000, 'h7000), 4'd1, 16'hF000, 4'd0, 16'h8000, 1'b0};
    tbl[4] = '{pk('h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h4000), 4'd9, 16'h4000, 4'd0, 16'd1, 1'b0};
    tbl[5] = '{pk('h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF, 'h3FFF), 4'd0, 16'h3FFF, 4'd1, 16'd0, 1'b1};

    #2;
    check("rst.in_ready", 32'(in_ready), 0);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.frame_count", 32'(frame_count), 0);
    check("rst.drop_count", 32'(drop_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.in_ready_after", 32'(in_ready), 1);

    for (int v = 0; v < 6; v++) begin
      send(tbl[v].prob);
      check($sformatf("v%0d.in_ready_scan", v), 32'(in_ready), 0);
      wait_valid(cyc);
      check($sformatf("v%0d.latency", v), 32'(cyc), 11);
      check_result($sformatf("v%0d", v), tbl[v]);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d.out_valid_drop", v), 32'(out_valid), 0);
    end
    check("tbl.frame_count", 32'(frame_count), 6);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    send(tbl[0].prob);
    send(tbl[3].prob);
    wait_valid(cyc);
    check("bp.valid_seen", 32'(out_valid), 1);
    held = tbl[0];
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      in_valid = (i == 5 || i == 15);
      prob_in = tbl[3].prob;
      if (!out_valid || class_out !== held.cls || conf_out !== held.conf || second_out !== held.sec ||
          margin_out !== held.margin || low_conf !== held.low) bad++;
    end
    check("bp.hold_stable", 32'(bad), 0);
    check_result("bp", held);
    check("bp.drop_count", 32'(drop_count), 3);
    check("bp.frame_count_held", 32'(frame_count), 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.frame_count", 32'(frame_count), 1);
    check("bp.out_valid_clear", 32'(out_valid), 0);

    out_ready = 1'b0;
    send(tbl[1].prob);
    wait_valid(cyc);
    check_result("b2b.first", tbl[1]);
    out_ready = 1'b1;
    prob_in = tbl[2].prob;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b.frame_count", 32'(frame_count), 2);
    check("b2b.drop_count", 32'(drop_count), 3);
    check("b2b.out_valid_clear", 32'(out_valid), 0);
    wait_valid(cyc);
    check("b2b.latency", 32'(cyc), 11);
    check_result("b2b.second", tbl[2]);
    @(posedge clk);
    @(negedge clk);
    check("b2b.frame_count_final", 32'(frame_count), 3);

    send(tbl[0].prob);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid.out_valid", 32'(out_valid), 0);
    check("mid.class_out", 32'(class_out), 0);
    check("mid.conf_out", 32'(conf_out), 0);
    check("mid.margin_out", 32'(margin_out), 0);
    check("mid.in_ready", 32'(in_ready), 0);
    check("mid.frame_count", 32'(frame_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid.in_ready_after", 32'(in_ready), 1);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("mid.no_partial", 32'(bad), 0);
    held = '{pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32767), 4'd9, 16'd32767, 4'd0, 16'd32767, 1'b0};
    send(held.prob);
    wait_valid(cyc);
    check("mid.latency", 32'(cyc), 11);
    check_result("mid", held);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
